// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle radix-2 restoring divider (DIV/DIVU) with start/ready handshake
module div_iter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W);
  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [DATA_W-1:0]   rem, rem_n;
  logic [DATA_W-1:0]   quot, quot_n;
  logic [DATA_W-1:0]   dvsr, dvsr_n;
  logic                neg_q, neg_q_n;
  logic                neg_r, neg_r_n;
  logic [2*DATA_W-1:0] result_n;
  logic                ready_n;

  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DATA_W:0]     rem_sh, trial;
  logic [DATA_W-1:0]   q_fix, r_fix;

  // Magnitudes are taken as unsigned, so |0x80000000| stays 0x80000000.
  always_comb begin
    op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + ONE) : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + ONE) : opdata2_i;
    rem_sh  = {rem, quot[DATA_W-1]};
    trial   = rem_sh - {1'b0, dvsr};
    q_fix   = neg_q ? (~quot + ONE) : quot;
    r_fix   = neg_r ? (~rem + ONE) : rem;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    quot_n   = quot;
    dvsr_n   = dvsr;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    result_n = result_o;
    ready_n  = ready_o;

    case (state)
      S_IDLE: begin
        ready_n  = 1'b0;
        result_n = '0;
        if (start_i && !annul_i) begin
          quot_n  = op1_abs;
          dvsr_n  = op2_abs;
          rem_n   = '0;
          cnt_n   = '0;
          neg_q_n = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_r_n = signed_div_i & opdata1_i[DATA_W-1];
          state_n = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end

      S_BYZERO: begin
        result_n = '0;
        ready_n  = 1'b0;
        state_n  = annul_i ? S_IDLE : S_END;
      end

      S_ON: begin
        if (annul_i) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == LAST_CNT) begin
          state_n  = S_END;
          result_n = {r_fix, q_fix};
          ready_n  = 1'b1;
        end else begin
          // No borrow keeps the difference; borrow restores the shifted remainder.
          if (!trial[DATA_W]) begin
            rem_n  = trial[DATA_W-1:0];
            quot_n = {quot[DATA_W-2:0], 1'b1};
          end else begin
            rem_n  = rem_sh[DATA_W-1:0];
            quot_n = {quot[DATA_W-2:0], 1'b0};
          end
          cnt_n = cnt + 1'b1;
        end
      end

      S_END: begin
        // Divide-by-zero enters here with ready low; it rises on the next held edge.
        if (!start_i) begin
          state_n  = S_IDLE;
          ready_n  = 1'b0;
          result_n = '0;
        end else begin
          ready_n = 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rem      <= '0;
      quot     <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rem      <= rem_n;
      quot     <= quot_n;
      dvsr     <= dvsr_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed self-checking bench for div_iter
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_iter #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // Drives a request at a negedge; the next posedge is the accept edge E0.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  // Counts posedges from E0 until ready_o is seen at a negedge (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!ready_o && n < 100);
  endtask

  task automatic release_op();
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_err++;
      $display("FAIL reset_state: ready=%b result=%h, want ready=0 result=0", ready_o, result_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned_basic();
    int n;
    issue(1'b0, 32'd7, 32'd2);
    wait_ready(n);
    n_vec++;
    if (n !== 34) begin
      n_err++;
      $display("FAIL u7div2_latency: edges=%0d want 34", n);
    end
    n_vec++;
    if (result_o !== 64'h00000001_00000003) begin
      n_err++;
      $display("FAIL u7div2_result: got %h want 0000000100000003", result_o);
    end
    release_op();
    n_vec++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_err++;
      $display("FAIL u7div2_drop: ready=%b result=%h want 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_signed();
    logic        s_tab [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] a_tab [3] = '{32'hFFFFFFF9, 32'h80000000, 32'h80000000};
    logic [31:0] b_tab [3] = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [63:0] r_tab [3] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000000_80000000, 64'h80000000_00000000};
    int n;
    for (int i = 0; i < 3; i++) begin
      issue(s_tab[i], a_tab[i], b_tab[i]);
      wait_ready(n);
      n_vec++;
      if (n !== 34 || result_o !== r_tab[i]) begin
        n_err++;
        $display("FAIL sign_case%0d: edges=%0d result=%h want edges=34 result=%h", i, n, result_o, r_tab[i]);
      end
      release_op();
    end
  endtask

  task automatic test_div_by_zero();
    int n;
    for (int m = 0; m < 2; m++) begin
      issue(m[0], 32'd5, 32'd0);
      wait_ready(n);
      n_vec++;
      if (n !== 3 || result_o !== 64'h0) begin
        n_err++;
        $display("FAIL byzero_mode%0d: edges=%0d result=%h want edges=3 result=0", m, n, result_o);
      end
      repeat (2) @(negedge clk);
      n_vec++;
      if (ready_o !== 1'b1 || result_o !== 64'h0) begin
        n_err++;
        $display("FAIL byzero_hold%0d: ready=%b result=%h want 1/0", m, ready_o, result_o);
      end
      release_op();
    end
  endtask

  task automatic test_annul();
    int n;
    int seen = 0;
    issue(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);   // E0..E9
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);               // E10
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL annul_no_ready: ready seen %0d cycles want 0", seen);
    end
    issue(1'b0, 32'd100, 32'd7);
    wait_ready(n);
    n_vec++;
    if (n !== 34 || result_o !== 64'h00000002_0000000E) begin
      n_err++;
      $display("FAIL annul_retry: edges=%0d result=%h want edges=34 result=000000020000000e", n, result_o);
    end
    release_op();
  endtask

  task automatic test_reset_mid();
    int n;
    issue(1'b0, 32'hFFFFFFFF, 32'd3);
    repeat (15) @(posedge clk);   // E0..E14
    @(negedge clk);
    #1 rst = 1'b1;
    start_i = 1'b0;
    #1;
    n_vec++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_err++;
      $display("FAIL midreset_outputs: ready=%b result=%h want 0/0", ready_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'd9, 32'd3);
    wait_ready(n);
    n_vec++;
    if (n !== 34 || result_o !== 64'h00000000_00000003) begin
      n_err++;
      $display("FAIL midreset_fresh: edges=%0d result=%h want edges=34 result=0000000000000003", n, result_o);
    end
    // Reset from END must clear the registered outputs without a clock edge.
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_err++;
      $display("FAIL endreset_async: ready=%b result=%h want 0/0", ready_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    int bad = 0;
    issue(1'b0, 32'd50, 32'd5);
    repeat (5) @(posedge clk);    // E0..E4
    @(negedge clk);
    opdata1_i = 32'd77;
    opdata2_i = 32'd3;
    signed_div_i = 1'b1;
    n = 5;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!ready_o && n < 100);
    n_vec++;
    if (n !== 34 || result_o !== 64'h00000000_0000000A) begin
      n_err++;
      $display("FAIL opchange_result: edges=%0d result=%h want edges=34 result=000000000000000a", n, result_o);
    end
    for (int i = 0; i < 4; i++) begin
      annul_i = (i == 1);
      @(negedge clk);
      if (ready_o !== 1'b1 || result_o !== 64'h00000000_0000000A) bad++;
    end
    annul_i = 1'b0;
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL end_hold: %0d unstable cycles want 0 (ready=%b result=%h)", bad, ready_o, result_o);
    end
    // Drop start for exactly one edge, then request again immediately.
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    issue(1'b0, 32'd13, 32'd4);
    wait_ready(n);
    n_vec++;
    if (n !== 34 || result_o !== 64'h00000001_00000003) begin
      n_err++;
      $display("FAIL back_to_back: edges=%0d result=%h want edges=34 result=0000000100000003", n, result_o);
    end
    release_op();
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_by_zero();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
